// File: rtl/btn_canvas_ctrl_pkg.sv
// Shared types and constants for the button-driven drawing canvas controller.
package btn_canvas_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EDIT = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam int unsigned GRID_W_DEFAULT = 28;
  localparam int unsigned GRID_H_DEFAULT = 28;
  localparam int unsigned NUM_PIX        = GRID_W_DEFAULT * GRID_H_DEFAULT;
  localparam int unsigned DIGIT_W        = 4;
  localparam int unsigned CRD_W          = 5;

endpackage

// File: rtl/btn_canvas_ctrl_canvas_cursor.sv
// Row/column wrap counter shared by the edit cursor and the SEND raster scan.
module canvas_cursor
  import btn_canvas_ctrl_pkg::*;
#(
  parameter int unsigned GRID_W = GRID_W_DEFAULT,
  parameter int unsigned GRID_H = GRID_H_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step_up,
  input  logic             step_right,
  output logic [CRD_W-1:0] row,
  output logic [CRD_W-1:0] col
);

  localparam logic [CRD_W-1:0] LAST_ROW = CRD_W'(GRID_H - 1);
  localparam logic [CRD_W-1:0] LAST_COL = CRD_W'(GRID_W - 1);

  logic [CRD_W-1:0] row_q, row_d, col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (step_up) begin
      row_d = (row_q == '0) ? LAST_ROW : row_q - CRD_W'(1);
    end else if (step_right) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + CRD_W'(1);
      end else begin
        col_d = col_q + CRD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/btn_canvas_ctrl.sv
// Button-driven binary drawing canvas: edit with cursor, stream raster to a
// classifier over valid/ready, then latch the returned digit.
module btn_canvas_ctrl
  import btn_canvas_ctrl_pkg::*;
#(
  parameter int unsigned GRID_W = GRID_W_DEFAULT,
  parameter int unsigned GRID_H = GRID_H_DEFAULT,
  parameter int unsigned IDX_W  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btnu_in,
  input  logic         btnc_in,
  input  logic         btnr_in,
  output logic         pix_data,
  output logic         pix_valid,
  output logic         pix_last,
  input  logic         pix_ready,
  input  logic         result_valid,
  input  logic [3:0]   result_digit,
  output logic [4:0]   cur_row,
  output logic [4:0]   cur_col,
  output logic [3:0]   digit_out,
  output logic         digit_valid,
  output logic         busy
);

  localparam int unsigned      PIX_TOTAL = GRID_W * GRID_H;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PIX_TOTAL - 1);

  state_e                         state_q, state_d;
  logic [GRID_H-1:0][GRID_W-1:0]  canvas_q, canvas_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [DIGIT_W-1:0]             digit_q, digit_d;
  logic                           digit_valid_q, digit_valid_d;
  logic                           busy_q, busy_d;
  logic [CRD_W-1:0]               edit_row, edit_col, scan_row, scan_col;
  logic                           in_edit, in_send, at_last;
  logic                           do_submit, do_clear, do_up, do_right, do_toggle;
  logic                           xfer;

  assign in_edit = (state_q == ST_EDIT);
  assign in_send = (state_q == ST_SEND);
  assign at_last = (idx_q == LAST_IDX);

  // Chord decode: submit beats clear beats single-button actions.
  assign do_submit = in_edit & btnu_in & btnr_in;
  assign do_clear  = in_edit & btnu_in & btnc_in & ~btnr_in;
  assign do_up     = in_edit & btnu_in & ~btnc_in & ~btnr_in;
  assign do_right  = in_edit & btnr_in & ~btnu_in;
  assign do_toggle = in_edit & btnc_in & ~btnu_in;
  assign xfer      = in_send & pix_ready;

  canvas_cursor #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_edit_cursor (
    .clk        (clk),
    .rst        (rst),
    .clr        (1'b0),
    .step_up    (do_up),
    .step_right (do_right),
    .row        (edit_row),
    .col        (edit_col)
  );

  canvas_cursor #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_scan_cursor (
    .clk        (clk),
    .rst        (rst),
    .clr        (do_submit),
    .step_up    (1'b0),
    .step_right (xfer),
    .row        (scan_row),
    .col        (scan_col)
  );

  always_comb begin
    state_d       = state_q;
    canvas_d      = canvas_q;
    idx_d         = idx_q;
    digit_d       = digit_q;
    digit_valid_d = digit_valid_q;
    unique case (state_q)
      ST_EDIT: begin
        if (do_submit) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end else if (do_clear) begin
          canvas_d      = '0;
          digit_valid_d = 1'b0;
        end else if (do_toggle) begin
          canvas_d[edit_row][edit_col] = ~canvas_q[edit_row][edit_col];
          digit_valid_d                = 1'b0;
        end
      end
      ST_SEND: begin
        if (xfer && at_last) state_d = ST_WAIT;
        else if (xfer)       idx_d   = idx_q + IDX_W'(1);
      end
      ST_WAIT: begin
        if (result_valid) begin
          digit_d       = result_digit;
          digit_valid_d = 1'b1;
          state_d       = ST_EDIT;
        end
      end
      default: state_d = ST_EDIT;
    endcase
    busy_d = (state_d != ST_EDIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EDIT;
      canvas_q      <= '0;
      idx_q         <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      canvas_q      <= canvas_d;
      idx_q         <= idx_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign pix_valid   = in_send;
  assign pix_data    = in_send & canvas_q[scan_row][scan_col];
  assign pix_last    = in_send & at_last;
  assign cur_row     = edit_row;
  assign cur_col     = edit_col;
  assign digit_out   = digit_q;
  assign digit_valid = digit_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_btn_canvas_ctrl.sv
// Directed/randomized bench for btn_canvas_ctrl against a positional canvas model.
module tb_btn_canvas_ctrl;

  localparam int GW = 28;
  localparam int GH = 28;
  localparam int NP = GW * GH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btnu_in = 1'b0, btnc_in = 1'b0, btnr_in = 1'b0;
  logic       pix_ready = 1'b0;
  logic       result_valid = 1'b0;
  logic [3:0] result_digit = '0;
  logic       pix_data, pix_valid, pix_last;
  logic [4:0] cur_row, cur_col;
  logic [3:0] digit_out;
  logic       digit_valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  int mr = 0, mc = 0, md = 0;
  bit mdv = 1'b0;
  bit mcan [GH][GW];

  btn_canvas_ctrl #(.GRID_W(GW), .GRID_H(GH), .IDX_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .btnu_in      (btnu_in),
    .btnc_in      (btnc_in),
    .btnr_in      (btnr_in),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready),
    .result_valid (result_valid),
    .result_digit (result_digit),
    .cur_row      (cur_row),
    .cur_col      (cur_col),
    .digit_out    (digit_out),
    .digit_valid  (digit_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; md = 0; mdv = 1'b0;
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) mcan[r][c] = 1'b0;
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_row"}, 32'(cur_row), 32'(mr));
    chk({tag, "_col"}, 32'(cur_col), 32'(mc));
  endtask

  // Button pulse while in EDIT; model applies the chord rules positionally.
  task automatic pulse(input bit u, input bit c, input bit r);
    int pos;
    @(negedge clk);
    btnu_in = u; btnc_in = c; btnr_in = r;
    @(posedge clk); #1;
    btnu_in = 1'b0; btnc_in = 1'b0; btnr_in = 1'b0;
    if (u && r) begin
      // submit: no model change
    end else if (u && c) begin
      for (int y = 0; y < GH; y++)
        for (int x = 0; x < GW; x++) mcan[y][x] = 1'b0;
      mdv = 1'b0;
    end else if (u) begin
      mr = (mr + GH - 1) % GH;
    end else begin
      if (c) begin
        mcan[mr][mc] = ~mcan[mr][mc];
        mdv = 1'b0;
      end
      if (r) begin
        pos = (mr * GW + mc + 1) % NP;
        mr = pos / GW;
        mc = pos % GW;
      end
    end
    chk_cursor("pulse");
    chk("pulse_dv", 32'(digit_valid), 32'(mdv));
    chk("pulse_busy", 32'(busy), 32'(u && r));
  endtask

  task automatic pulse_ignored(input bit u, input bit c, input bit r);
    @(negedge clk);
    btnu_in = u; btnc_in = c; btnr_in = r;
    @(posedge clk); #1;
    btnu_in = 1'b0; btnc_in = 1'b0; btnr_in = 1'b0;
    chk_cursor("wait_btn");
    chk("wait_busy", 32'(busy), 32'(1));
    chk("wait_valid", 32'(pix_valid), 32'(0));
  endtask

  task automatic result(input int d, input bit in_wait);
    @(negedge clk);
    result_valid = 1'b1; result_digit = 4'(d);
    @(posedge clk); #1;
    result_valid = 1'b0;
    if (in_wait) begin
      md = d; mdv = 1'b1;
    end
    chk("res_digit", 32'(digit_out), 32'(md));
    chk("res_dv", 32'(digit_valid), 32'(mdv));
    chk("res_busy", 32'(busy), 32'(0));
  endtask

  // Stream the canvas; stop_at >= 0 returns on the negedge where that many transfers are done.
  task automatic stream(input bit rnd, input int stop_at);
    bit exp_pix [NP];
    int k = 0;
    int cyc = 0;
    for (int i = 0; i < NP; i++) exp_pix[i] = mcan[i / GW][i % GW];
    while (k < NP) begin
      @(negedge clk);
      if (cyc >= 20000) begin
        chk("send_timeout", 32'(k), 32'(NP));
        break;
      end
      if (stop_at >= 0 && k == stop_at) return;
      chk("send_valid", 32'(pix_valid), 32'(1));
      chk("send_data", 32'(pix_data), 32'(exp_pix[k]));
      chk("send_last", 32'(pix_last), 32'(k == NP - 1));
      chk("send_busy", 32'(busy), 32'(1));
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        btnu_in = 1'($urandom_range(0, 1));
        btnc_in = 1'($urandom_range(0, 1));
        btnr_in = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (pix_ready) k++;
      cyc++;
    end
    pix_ready = 1'b0;
    btnu_in = 1'b0; btnc_in = 1'b0; btnr_in = 1'b0;
    @(negedge clk);
    chk("wait_valid_drop", 32'(pix_valid), 32'(0));
    chk("wait_busy", 32'(busy), 32'(1));
    chk_cursor("after_send");
  endtask

  initial begin
    bit u, c, r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(pix_valid), 32'(0));
    chk("rst_last", 32'(pix_last), 32'(0));
    chk("rst_data", 32'(pix_data), 32'(0));
    chk("rst_digit", 32'(digit_out), 32'(0));
    chk("rst_dv", 32'(digit_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk_cursor("rst");
    rst = 1'b0;

    // Cursor wrap: full row of rights, then up across row 0.
    repeat (GW) pulse(0, 0, 1);
    chk("wrap_row1", 32'(cur_row), 32'(1));
    repeat (2) pulse(1, 0, 0);
    chk("up_wrap_row", 32'(cur_row), 32'(GH - 1));

    // Mark (27,27) and (0,0).
    repeat (GW - 1) pulse(0, 0, 1);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    pulse(0, 1, 0);
    result(3, 1'b0);

    pulse(1, 0, 1);
    stream(1'b0, -1);
    pulse_ignored(0, 1, 0);
    pulse_ignored(0, 0, 1);
    pulse_ignored(1, 0, 1);
    result(7, 1'b1);
    pulse(0, 1, 0);

    // Random editing, then a stalled stream.
    repeat (80) begin
      u = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (u && r) r = 1'b0;
      pulse(u, c, r);
    end
    pulse(1, 0, 1);
    stream(1'b1, -1);
    result(int'($urandom_range(0, 9)), 1'b1);

    // Clear chord wipes the canvas.
    repeat (5) pulse(0, 1, 1);
    pulse(1, 1, 0);
    pulse(1, 0, 1);
    stream(1'b1, -1);
    result(2, 1'b1);

    // Reset in the middle of a stream.
    repeat (6) pulse(0, 1, 1);
    pulse(1, 0, 1);
    stream(1'b1, 400);
    rst = 1'b1; pix_ready = 1'b0;
    btnu_in = 1'b0; btnc_in = 1'b0; btnr_in = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("midrst_valid", 32'(pix_valid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_dv", 32'(digit_valid), 32'(0));
    chk_cursor("midrst");
    rst = 1'b0;
    pulse(1, 0, 1);
    stream(1'b0, -1);
    result(5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
